// File: rtl/dcls_pkg.sv
// Shared DCLS definitions: FSM state encoding (also used by the comparator),
// self-test status codes and the comparator error-latency helper.
package dcls_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WARMUP = 3'd1,
        RUN    = 3'd2,
        INJECT = 3'd3,
        DRAIN  = 3'd4
    } dcls_state_e;

    localparam logic [1:0] TS_PASS  = 2'd0;
    localparam logic [1:0] TS_MISS  = 2'd1;
    localparam logic [1:0] TS_COUNT = 2'd2;
    localparam logic [1:0] TS_ABORT = 2'd3;

    function automatic int dcls_latency(input int num_or_stages);
        return 2 + num_or_stages;
    endfunction

endpackage

// File: rtl/dcls_error_monitor.sv
// Drives the DCLS comparator controls, sequences the single-bit fault-injection
// self-test and keeps sticky mismatch / pair-fault / test status for the safety controller.
module dcls_error_monitor
    import dcls_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_OR_STAGES = 0
) (
    input  logic                                CLK,
    input  logic                                RESETN,
    input  logic                                ENABLE,
    input  logic                                TEST_REQ,
    input  logic                                CLEAR,
    input  logic                                ERR_DCLS,
    input  logic                                ERR_DCLS_B,
    input  logic                                VALID_OUT,
    input  logic                                IS_FIERR_OUT,
    output logic                                ENERR_DCLS,
    output logic                                FIERR_DCLS,
    output logic                                TEST_BUSY,
    output logic                                TEST_DONE,
    output logic [1:0]                          TEST_STATUS,
    output logic [$clog2(2*DATA_WIDTH)-1:0]     TEST_FAIL_INDEX,
    output logic                                CORE_MISMATCH,
    output logic                                PAIR_FAULT,
    output logic                                IRQ
);

    localparam int NINJ = 2 * DATA_WIDTH;
    localparam int IDXW = $clog2(NINJ);
    localparam int SCW  = IDXW + 1;
    localparam int L    = dcls_latency(NUM_OR_STAGES);

    localparam logic [SCW-1:0] NINJ_S     = SCW'(NINJ);
    localparam logic [SCW-1:0] INJ_LAST   = SCW'(NINJ - 1);
    localparam logic [SCW-1:0] DRAIN_LAST = SCW'(L + 3);

    dcls_state_e     state, state_nxt;
    logic [SCW-1:0]  cnt;       // INJECT length, then DRAIN timeout
    logic [SCW-1:0]  scnt;      // one spare bit so extra samples stay visible
    logic            miss_q;
    logic [IDXW-1:0] fail_idx_q;
    logic [1:0]      status_q;
    logic            core_q, pair_q, irq_q, enerr_q, fierr_q;
    logic            busy, start, done;
    logic [1:0]      done_code;
    logic            core_set, pair_set;

    assign busy     = (state == INJECT) || (state == DRAIN);
    assign start    = (state == RUN) && (state_nxt == INJECT);
    assign core_set = ERR_DCLS && !IS_FIERR_OUT && (state != IDLE);
    assign pair_set = (ERR_DCLS == ERR_DCLS_B);

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        done_code = TS_PASS;
        unique case (state)
            IDLE:   if (ENABLE) state_nxt = WARMUP;
            WARMUP: if (VALID_OUT) state_nxt = RUN;
            RUN:    if (TEST_REQ) state_nxt = INJECT;
            INJECT: if (cnt == INJ_LAST) state_nxt = DRAIN;
            DRAIN: begin
                // Extra samples keep scnt past NINJ, so they end in the timeout (status 2)
                if (scnt == NINJ_S && !IS_FIERR_OUT) begin
                    done      = 1'b1;
                    done_code = miss_q ? TS_MISS : TS_PASS;
                    state_nxt = RUN;
                end else if (cnt == DRAIN_LAST) begin
                    done      = 1'b1;
                    done_code = TS_COUNT;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (state != IDLE && !ENABLE) begin
            state_nxt = IDLE;
            done      = busy;
            done_code = TS_ABORT;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state      <= IDLE;
            cnt        <= '0;
            scnt       <= '0;
            miss_q     <= 1'b0;
            fail_idx_q <= '0;
            status_q   <= TS_PASS;
            core_q     <= 1'b0;
            pair_q     <= 1'b0;
            irq_q      <= 1'b0;
            enerr_q    <= 1'b0;
            fierr_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            enerr_q <= (state_nxt != IDLE);
            fierr_q <= (state_nxt == INJECT);

            if (state_nxt != state) cnt <= '0;
            else if (busy)          cnt <= cnt + SCW'(1);

            if (start) begin
                scnt       <= '0;
                miss_q     <= 1'b0;
                fail_idx_q <= '0;
            end else if (busy && IS_FIERR_OUT) begin
                scnt <= scnt + SCW'(1);
                if (!ERR_DCLS && !miss_q) begin
                    miss_q     <= 1'b1;
                    fail_idx_q <= scnt[IDXW-1:0];
                end
            end

            // Set events take priority over CLEAR
            if (done)       status_q <= done_code;
            else if (CLEAR) status_q <= TS_PASS;

            if (core_set)   core_q <= 1'b1;
            else if (CLEAR) core_q <= 1'b0;

            if (pair_set)   pair_q <= 1'b1;
            else if (CLEAR) pair_q <= 1'b0;

            irq_q <= core_q | pair_q | (status_q != TS_PASS);
        end
    end

    assign ENERR_DCLS      = enerr_q;
    assign FIERR_DCLS      = fierr_q;
    assign TEST_BUSY       = busy;
    assign TEST_DONE       = done;
    assign TEST_STATUS     = status_q;
    assign TEST_FAIL_INDEX = fail_idx_q;
    assign CORE_MISMATCH   = core_q;
    assign PAIR_FAULT      = pair_q;
    assign IRQ             = irq_q;

endmodule

// File: tb/tb_dcls_error_monitor.sv
// Directed bench for dcls_error_monitor with a small loopback comparator model (DW=32, L=2).
module tb_dcls_error_monitor;
    import dcls_pkg::*;

    logic       CLK = 1'b0;
    logic       RESETN, ENABLE, TEST_REQ, CLEAR;
    logic       ERR_DCLS, ERR_DCLS_B, VALID_OUT, IS_FIERR_OUT;
    logic       ENERR_DCLS, FIERR_DCLS, TEST_BUSY, TEST_DONE;
    logic [1:0] TEST_STATUS;
    logic [5:0] TEST_FAIL_INDEX;
    logic       CORE_MISMATCH, PAIR_FAULT, IRQ;

    int n_chk = 0;
    int n_err = 0;

    // comparator model controls
    logic drop_mode = 1'b0, nofi_mode = 1'b0, force_err = 1'b0, force_pair = 1'b0;
    logic [2:0] fpipe = '0;
    logic [1:0] vpipe = '0;
    int kcnt = 0;

    dcls_error_monitor #(.DATA_WIDTH(32), .NUM_OR_STAGES(0)) dut (
        .CLK(CLK), .RESETN(RESETN), .ENABLE(ENABLE), .TEST_REQ(TEST_REQ), .CLEAR(CLEAR),
        .ERR_DCLS(ERR_DCLS), .ERR_DCLS_B(ERR_DCLS_B), .VALID_OUT(VALID_OUT),
        .IS_FIERR_OUT(IS_FIERR_OUT), .ENERR_DCLS(ENERR_DCLS), .FIERR_DCLS(FIERR_DCLS),
        .TEST_BUSY(TEST_BUSY), .TEST_DONE(TEST_DONE), .TEST_STATUS(TEST_STATUS),
        .TEST_FAIL_INDEX(TEST_FAIL_INDEX), .CORE_MISMATCH(CORE_MISMATCH),
        .PAIR_FAULT(PAIR_FAULT), .IRQ(IRQ)
    );

    always #5 CLK = ~CLK;

    // injection returns as a sample L+1 cycles after FIERR_DCLS is presented
    always @(posedge CLK) begin
        fpipe <= {fpipe[1:0], FIERR_DCLS};
        vpipe <= {vpipe[0], ENERR_DCLS};
        if (IS_FIERR_OUT)     kcnt <= kcnt + 1;
        else if (!FIERR_DCLS) kcnt <= 0;
    end

    assign IS_FIERR_OUT = nofi_mode ? 1'b0 : fpipe[2];
    assign VALID_OUT    = vpipe[1];
    assign ERR_DCLS     = force_err | (IS_FIERR_OUT & ~(drop_mode & (kcnt == 5 || kcnt == 9)));
    assign ERR_DCLS_B   = force_pair ? ERR_DCLS : ~ERR_DCLS;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // TEST_REQ is high in cycle 0; observes cycles 1..ncyc at 3 time units past the edge
    task automatic run_test(input int ncyc, output int f_first, output int f_last,
                            output int d_cyc, output int d_cnt, output int b_done);
        f_first = -1; f_last = -1; d_cyc = -1; d_cnt = 0; b_done = 0;
        tick();
        TEST_REQ = 1'b1;
        for (int rel = 1; rel <= ncyc; rel++) begin
            tick();
            TEST_REQ = 1'b0;
            #2;
            if (FIERR_DCLS) begin
                if (f_first < 0) f_first = rel;
                f_last = rel;
            end
            if (TEST_DONE) begin
                if (d_cyc < 0) d_cyc = rel;
                d_cnt++;
                b_done = TEST_BUSY;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int ff, fl, dc, dn, bd;
        RESETN = 1'b0; ENABLE = 1'b0; TEST_REQ = 1'b0; CLEAR = 1'b0;
        repeat (3) tick();
        #2;
        chk("reset_outs", 32'({ENERR_DCLS, FIERR_DCLS, TEST_BUSY, TEST_DONE, TEST_STATUS,
                               TEST_FAIL_INDEX, CORE_MISMATCH, PAIR_FAULT, IRQ}), 0);
        tick();
        RESETN = 1'b1;
        tick();
        ENABLE = 1'b1;                         // cycle t
        #2; chk("enerr_t", 32'(ENERR_DCLS), 0);
        tick(); #2; chk("enerr_t1", 32'(ENERR_DCLS), 1);
        tick(); tick(); #2; chk("warmup_t3", 32'(dut.state), 32'(WARMUP));
        tick(); #2; chk("run_t4", 32'(dut.state), 32'(RUN));
        repeat (3) tick();
        #2; chk("flags_warm", 32'({CORE_MISMATCH, PAIR_FAULT, TEST_STATUS, IRQ}), 0);

        // healthy comparator
        run_test(72, ff, fl, dc, dn, bd);
        chk("ok_fierr_first", 32'(ff), 1);
        chk("ok_fierr_last", 32'(fl), 64);
        chk("ok_done_cyc", 32'(dc), 68);
        chk("ok_done_cnt", 32'(dn), 1);
        chk("ok_busy_at_done", 32'(bd), 1);
        chk("ok_busy_after", 32'(TEST_BUSY), 0);
        chk("ok_status", 32'(TEST_STATUS), 0);
        chk("ok_irq", 32'(IRQ), 0);
        chk("ok_flags", 32'({CORE_MISMATCH, PAIR_FAULT}), 0);

        // comparator misses injections 5 and 9
        drop_mode = 1'b1;
        run_test(72, ff, fl, dc, dn, bd);
        drop_mode = 1'b0;
        chk("miss_done_cyc", 32'(dc), 68);
        chk("miss_status", 32'(TEST_STATUS), 1);
        chk("miss_index", 32'(TEST_FAIL_INDEX), 5);
        chk("miss_irq", 32'(IRQ), 1);
        chk("miss_core", 32'(CORE_MISMATCH), 0);
        tick(); CLEAR = 1'b1;
        tick(); CLEAR = 1'b0;
        #2; chk("miss_cleared", 32'(TEST_STATUS), 0);

        // comparator never returns samples: DRAIN timeout after L+4 cycles
        nofi_mode = 1'b1;
        run_test(76, ff, fl, dc, dn, bd);
        nofi_mode = 1'b0;
        chk("to_done_cyc", 32'(dc), 70);
        chk("to_done_cnt", 32'(dn), 1);
        chk("to_status", 32'(TEST_STATUS), 2);
        chk("to_state_run", 32'(dut.state), 32'(RUN));
        tick(); CLEAR = 1'b1;
        tick(); CLEAR = 1'b0;
        #2; chk("to_cleared", 32'(TEST_STATUS), 0);
        tick(); #2; chk("to_irq_clr", 32'(IRQ), 0);

        // real mismatch and pair fault in RUN
        tick(); force_err = 1'b1;
        tick(); force_err = 1'b0;
        #2; chk("core_set", 32'({CORE_MISMATCH, PAIR_FAULT}), 32'b10);
        tick(); #2; chk("core_irq", 32'(IRQ), 1);
        tick(); force_pair = 1'b1;
        tick(); force_pair = 1'b0;
        #2; chk("pair_set", 32'({CORE_MISMATCH, PAIR_FAULT}), 32'b11);
        repeat (3) tick();
        #2; chk("sticky_hold", 32'({CORE_MISMATCH, PAIR_FAULT}), 32'b11);
        tick(); CLEAR = 1'b1;
        tick(); CLEAR = 1'b0;
        #2; chk("clear_both", 32'({CORE_MISMATCH, PAIR_FAULT}), 0);
        tick(); CLEAR = 1'b1; force_err = 1'b1; force_pair = 1'b1;
        tick(); CLEAR = 1'b0; force_err = 1'b0; force_pair = 1'b0;
        #2; chk("set_beats_clear", 32'({CORE_MISMATCH, PAIR_FAULT}), 32'b11);
        tick(); CLEAR = 1'b1;
        tick(); CLEAR = 1'b0;
        #2; chk("clear_again", 32'({CORE_MISMATCH, PAIR_FAULT}), 0);
        repeat (2) tick();
        #2; chk("irq_quiet", 32'(IRQ), 0);

        // ENABLE dropped in cycle 30 of INJECT
        tick(); TEST_REQ = 1'b1;
        tick(); TEST_REQ = 1'b0;
        repeat (29) tick();
        ENABLE = 1'b0;
        #2;
        chk("ab_done_pulse", 32'({TEST_DONE, FIERR_DCLS, ENERR_DCLS}), 32'b111);
        tick(); #2;
        chk("ab_ctrl_drop", 32'({FIERR_DCLS, ENERR_DCLS, TEST_DONE, TEST_BUSY}), 0);
        chk("ab_state_idle", 32'(dut.state), 32'(IDLE));
        chk("ab_status", 32'(TEST_STATUS), 3);
        tick(); #2;
        chk("ab_irq", 32'(IRQ), 1);
        chk("ab_no_mm", 32'({CORE_MISMATCH, PAIR_FAULT}), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dcls_error_monitor.md
# dcls_error_monitor

Controller and checker on the output side of the DCLS comparator. It drives the comparator's `ENERR_DCLS`/`FIERR_DCLS` controls and sequences the built-in fault-injection self-test, sweeping all `2*DATA_WIDTH` single-bit injections. It classifies each returned error sample as test response or real core mismatch, checks the complementary error pair, and reports sticky status and an interrupt to the safety controller.

## Interface
- `DATA_WIDTH`, 32: comparator data width; self-test length is `2*DATA_WIDTH` injections.
- `NUM_OR_STAGES`, 0: comparator OR-pipeline depth; comparator error latency `L = 2 + NUM_OR_STAGES`.
- `CLK`  in  1  single clock.
- `RESETN`  in  1  asynchronous, active-low reset.
- `ENABLE`  in  1  software enable for DCLS checking (level).
- `TEST_REQ`  in  1  self-test start pulse.
- `CLEAR`  in  1  clears sticky flags (pulse).
- `ERR_DCLS`, `ERR_DCLS_B`, `VALID_OUT`, `IS_FIERR_OUT`  in  1 each  from comparator.
- `ENERR_DCLS`  out  1  comparator enable, registered.
- `FIERR_DCLS`  out  1  comparator fault-test request, registered.
- `TEST_BUSY`  out  1  self-test in progress.
- `TEST_DONE`  out  1  one-cycle pulse when a test ends.
- `TEST_STATUS`  out  2  0 = pass, 1 = missed detection, 2 = sample count/timeout error, 3 = aborted. Holds until the next test ends.
- `TEST_FAIL_INDEX`  out  `$clog2(2*DATA_WIDTH)`  index of the first injection that read `ERR_DCLS=0`.
- `CORE_MISMATCH`  out  1  sticky real-mismatch flag.
- `PAIR_FAULT`  out  1  sticky flag: `ERR_DCLS == ERR_DCLS_B` was observed.
- `IRQ`  out  1  registered `CORE_MISMATCH | PAIR_FAULT | (TEST_STATUS != 0)`.

## Operation
- **Reset:** every output is 0; the FSM is in IDLE.
- **IDLE:**
  - `ENERR_DCLS = 0`.
  - `ENABLE = 1` moves to WARMUP.
- **WARMUP:**
  - `ENERR_DCLS = 1`.
  - Waits for `VALID_OUT = 1`, then moves to RUN.
- **RUN:**
  - Normal monitoring.
  - `TEST_REQ` moves to INJECT and clears the sample counter and the first-fail record.
  - `TEST_REQ` in any other state is dropped.
- **INJECT:**
  - `FIERR_DCLS = 1` for exactly `2*DATA_WIDTH` cycles, then moves to DRAIN.
- **DRAIN:**
  - `FIERR_DCLS = 0`.
  - Completes when the sample count equals `2*DATA_WIDTH` and `IS_FIERR_OUT = 0`.
  - On completion: pulse `TEST_DONE`, update `TEST_STATUS`, return to RUN.
  - If not complete after `L+4` DRAIN cycles: status 2, finish.
- **Sampling (INJECT and DRAIN):**
  - Each cycle with `IS_FIERR_OUT = 1` is one sample `k` (counter value).
  - `ERR_DCLS = 0` on a sample gives status 1. `TEST_FAIL_INDEX` records the first such `k`; later misses do not overwrite it.
  - A count above `2*DATA_WIDTH` gives status 2.
  - Status priority: 3 > 2 > 1.
- **Real mismatch:** `ERR_DCLS = 1` with `IS_FIERR_OUT = 0` in WARMUP, RUN, INJECT or DRAIN sets `CORE_MISMATCH`.
- **Pair check:** active in every state including IDLE. `ERR_DCLS == ERR_DCLS_B` sets `PAIR_FAULT`.
- **CLEAR:** clears `CORE_MISMATCH`, `PAIR_FAULT` and `TEST_STATUS`. If a set event occurs in the same cycle, set wins.
- **`ENABLE` falls:**
  - From any non-IDLE state: go to IDLE; `ENERR_DCLS` and `FIERR_DCLS` drop the next cycle.
  - If it falls during INJECT or DRAIN: pulse `TEST_DONE`, status 3.
  - Sticky flags are kept.
- **Reset mid-test:** all state is lost; outputs return to reset values immediately (asynchronous).

## Timing
- `TEST_REQ` is sampled in RUN at cycle T. Then:
  - `FIERR_DCLS = 1` during T+1 .. T+2DW.
  - Expected samples at T+2+L .. T+1+2DW+L.
  - `TEST_DONE` at T+2+2DW+L.
  - `TEST_BUSY = 1` from T+1 through the `TEST_DONE` cycle.
- For DW=32, L=2, T=0: `FIERR_DCLS` high in cycles 1..64, samples in cycles 4..67, `TEST_DONE` in cycle 68.
- `ENABLE` rises in cycle t → `ENERR_DCLS = 1` from t+1. RUN is entered the cycle after `VALID_OUT` is first seen high.
- Sticky flags and `TEST_STATUS` update one cycle after the causing input. `IRQ` follows one cycle later.

## Structure
- Package `dcls_pkg`:
  - FSM state enum (IDLE, WARMUP, RUN, INJECT, DRAIN).
  - `TEST_STATUS` code localparams.
  - Constant function `dcls_latency(num_or_stages)` returning `2 + num_or_stages`.
  - This package is shared with the comparator's state encoding.
- A single module; no sub-module. Contents:
  - One counter reused for the INJECT length and the DRAIN timeout.
  - A separate sample counter, `$clog2(2*DATA_WIDTH)+1` bits wide, so the overflow case is detectable.

## Test plan
- **Reset release, comparator loopback, `ENABLE = 1`:** `ENERR_DCLS = 1` next cycle; RUN reached after `VALID_OUT`; all flags stay 0.
- **`TEST_REQ` at cycle 0, healthy comparator (DW=32, L=2):** `FIERR_DCLS` high in cycles 1..64; `TEST_DONE` in cycle 68; `TEST_STATUS = 0`; `IRQ = 0`.
- **Comparator model drops `ERR_DCLS` on injections 5 and 9:** `TEST_STATUS = 1`, `TEST_FAIL_INDEX = 5`, `IRQ = 1`.
- **Model never asserts `IS_FIERR_OUT`:** status 2 once the DRAIN timeout expires (`L+4` cycles); `TEST_DONE` pulses once.
- **`ERR_DCLS = 1` with `IS_FIERR_OUT = 0` in RUN, and a forced `ERR_DCLS_B = ERR_DCLS` cycle:**
  - `CORE_MISMATCH` and `PAIR_FAULT` set and held.
  - `CLEAR` clears them.
  - `CLEAR` coincident with a new error leaves the flag set.
- **`ENABLE` dropped at cycle 30 of INJECT:** `FIERR_DCLS` and `ENERR_DCLS` go to 0 the next cycle; `TEST_DONE` pulses with status 3; FSM is in IDLE.
